// File: rtl/tlp_reassembly_buffer.sv
// Collects 128-bit locations (1 or 2 per cycle) into one wide TLP word of up to MAX_LOC locations.
// Latency: out_valid rises on the edge that accepts in_last; outputs are held stable until out_ready.
// Backpressure: in_ready drops for the whole PRESENT phase. Overflow drop/err_overflow only with TLP_REASM_OVF_CHECK_EN.
module tlp_reassembly_buffer #(
    parameter int DW      = 32,
    parameter int LOC_W   = 4*DW,
    parameter int MAX_LOC = 9
) (
    input  logic                     clk,
    input  logic                     arst,
    input  logic                     in_valid,
    input  logic                     in_mode,
    input  logic [LOC_W-1:0]         in_data_1,
    input  logic [LOC_W-1:0]         in_data_2,
    input  logic                     in_last,
    output logic                     in_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [MAX_LOC*LOC_W-1:0] out_data,
    output logic [3:0]               out_no_loc,
    output logic                     err_overflow
);

    localparam int         OUT_W   = MAX_LOC*LOC_W;
    localparam logic [4:0] MAX_SUM = 5'(MAX_LOC);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_PRESENT = 2'd2
`ifdef TLP_REASM_OVF_CHECK_EN
        ,
        ST_DROP    = 2'd3
`endif
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         loc_cnt_q, loc_cnt_d;
    logic [LOC_W-1:0]   slot_q [MAX_LOC];
    logic               accept;
    logic [4:0]         loc_sum;
    logic [3:0]         wr_idx2;
    logic               wr1, wr2, clr;
    logic               err_d;

    assign in_ready = !arst && (state_q != ST_PRESENT);
    assign accept   = in_valid && in_ready;
    assign loc_sum  = {1'b0, loc_cnt_q} + {4'b0, in_mode} + 5'd1;
    assign wr_idx2  = loc_cnt_q + 4'd1;

    always_comb begin
        state_d   = state_q;
        loc_cnt_d = loc_cnt_q;
        wr1       = 1'b0;
        wr2       = 1'b0;
        clr       = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            ST_IDLE, ST_COLLECT: begin
                if (accept) begin
`ifdef TLP_REASM_OVF_CHECK_EN
                    if (loc_sum > MAX_SUM) begin
                        err_d     = 1'b1;
                        clr       = 1'b1;
                        loc_cnt_d = 4'd0;
                        state_d   = in_last ? ST_IDLE : ST_DROP;
                    end else
`endif
                    begin
                        // Slots at or beyond MAX_LOC never match a slot index, so they drop out naturally.
                        wr1       = 1'b1;
                        wr2       = in_mode;
                        loc_cnt_d = (loc_sum > MAX_SUM) ? MAX_SUM[3:0] : loc_sum[3:0];
                        state_d   = in_last ? ST_PRESENT : ST_COLLECT;
                    end
                end
            end
            ST_PRESENT: begin
                if (out_ready) begin
                    clr       = 1'b1;
                    loc_cnt_d = 4'd0;
                    state_d   = ST_IDLE;
                end
            end
`ifdef TLP_REASM_OVF_CHECK_EN
            ST_DROP: begin
                if (accept && in_last) begin
                    state_d = ST_IDLE;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            state_q   <= ST_IDLE;
            loc_cnt_q <= 4'd0;
        end else begin
            state_q   <= state_d;
            loc_cnt_q <= loc_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < MAX_LOC; k++) begin
            if (arst || clr) begin
                slot_q[k] <= '0;
            end else begin
                if (wr1 && (loc_cnt_q == 4'(k))) begin
                    slot_q[k] <= in_data_1;
                end
                if (wr2 && (wr_idx2 == 4'(k))) begin
                    slot_q[k] <= in_data_2;
                end
            end
        end
    end

`ifdef TLP_REASM_OVF_CHECK_EN
    always_ff @(posedge clk) begin
        if (arst) begin
            err_overflow <= 1'b0;
        end else begin
            err_overflow <= err_d;
        end
    end
`else
    assign err_overflow = 1'b0;
`endif

    assign out_valid  = (state_q == ST_PRESENT);
    assign out_no_loc = (state_q == ST_PRESENT) ? loc_cnt_q : 4'd0;

    // Location 0 occupies the most significant slice.
    always_comb begin
        out_data = '0;
        for (int k = 0; k < MAX_LOC; k++) begin
            out_data[OUT_W-1-k*LOC_W -: LOC_W] = slot_q[k];
        end
    end

endmodule

// File: tb/tb_tlp_reassembly_buffer.sv
// Directed bench for tlp_reassembly_buffer; expected values are hand-derived constants.
module tb_tlp_reassembly_buffer;

    localparam int LOC_W   = 128;
    localparam int MAX_LOC = 9;
    localparam int OUT_W   = LOC_W*MAX_LOC;

    logic               clk = 1'b0;
    logic               arst;
    logic               in_valid;
    logic               in_mode;
    logic [LOC_W-1:0]   in_data_1;
    logic [LOC_W-1:0]   in_data_2;
    logic               in_last;
    logic               in_ready;
    logic               out_valid;
    logic               out_ready;
    logic [OUT_W-1:0]   out_data;
    logic [3:0]         out_no_loc;
    logic               err_overflow;

    int n_checks = 0;
    int n_fail   = 0;

    tlp_reassembly_buffer dut (
        .clk          (clk),
        .arst         (arst),
        .in_valid     (in_valid),
        .in_mode      (in_mode),
        .in_data_1    (in_data_1),
        .in_data_2    (in_data_2),
        .in_last      (in_last),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_no_loc   (out_no_loc),
        .err_overflow (err_overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [LOC_W-1:0] loc(input logic [7:0] b);
        return {16{b}};
    endfunction

    function automatic logic [LOC_W-1:0] slot(input int k);
        return out_data[OUT_W-1-k*LOC_W -: LOC_W];
    endfunction

    task automatic check(input string tag, input logic [LOC_W-1:0] obs, input logic [LOC_W-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic mode, input logic [LOC_W-1:0] d1, input logic [LOC_W-1:0] d2,
                        input logic last);
        in_valid  = 1'b1;
        in_mode   = mode;
        in_data_1 = d1;
        in_data_2 = d2;
        in_last   = last;
        step();
        in_valid  = 1'b0;
        in_last   = 1'b0;
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, "_valid_low"}, out_valid, 0);
        check({tag, "_ready_high"}, in_ready, 1);
        check({tag, "_no_loc_zero"}, out_no_loc, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        arst      = 1'b1;
        in_valid  = 1'b0;
        in_mode   = 1'b0;
        in_data_1 = '0;
        in_data_2 = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        step();
        step();

        // Reset state
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_no_loc", out_no_loc, 0);
        check("rst_err", err_overflow, 0);
        check("rst_slot0", slot(0), 0);
        arst = 1'b0;
        #1;
        check("rel_in_ready", in_ready, 1);

        // Three single accepts
        push(0, loc(8'hA1), '0, 0);
        check("t1_no_valid_mid", out_valid, 0);
        push(0, loc(8'hB2), '0, 0);
        push(0, loc(8'hC3), '0, 1);
        check("t1_valid", out_valid, 1);
        check("t1_no_loc", out_no_loc, 3);
        check("t1_slot0", slot(0), loc(8'hA1));
        check("t1_slot1", slot(1), loc(8'hB2));
        check("t1_slot2", slot(2), loc(8'hC3));
        check("t1_slot3", slot(3), 0);
        check("t1_slot8", slot(8), 0);
        check("t1_in_ready", in_ready, 0);
        handshake("t1_hs");

        // Full 9-location TLP
        push(1, loc(8'h21), loc(8'h22), 0);
        push(1, loc(8'h23), loc(8'h24), 0);
        push(1, loc(8'h25), loc(8'h26), 0);
        push(1, loc(8'h27), loc(8'h28), 0);
        check("t2_in_ready_mid", in_ready, 1);
        push(0, loc(8'h29), '0, 1);
        check("t2_valid", out_valid, 1);
        check("t2_no_loc", out_no_loc, 9);
        check("t2_err", err_overflow, 0);
        check("t2_in_ready", in_ready, 0);
        for (int k = 0; k < MAX_LOC; k++) begin
            check($sformatf("t2_slot%0d", k), slot(k), loc(8'(8'h21 + k)));
        end

        // Held output while upstream keeps offering data
        in_valid  = 1'b1;
        in_mode   = 1'b1;
        in_data_1 = loc(8'hEE);
        in_data_2 = loc(8'hEF);
        in_last   = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            check($sformatf("t3_valid_c%0d", c), out_valid, 1);
            check($sformatf("t3_slot0_c%0d", c), slot(0), loc(8'h21));
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("t3_no_loc", out_no_loc, 9);
        check("t3_slot8", slot(8), loc(8'h29));
        handshake("t3_hs");

        // Overflow at loc_cnt=8 with a dual accept
        push(1, loc(8'h31), loc(8'h32), 0);
        push(1, loc(8'h33), loc(8'h34), 0);
        push(1, loc(8'h35), loc(8'h36), 0);
        push(1, loc(8'h37), loc(8'h38), 0);
        push(1, loc(8'h39), loc(8'h3A), 0);
`ifdef TLP_REASM_OVF_CHECK_EN
        check("t4_err_pulse", err_overflow, 1);
        check("t4_no_valid", out_valid, 0);
        check("t4_drop_ready", in_ready, 1);
        push(0, loc(8'h3B), '0, 0);
        check("t4_err_once", err_overflow, 0);
        check("t4_drop_no_valid", out_valid, 0);
        push(0, loc(8'h3C), '0, 1);
        check("t4_drop_end_no_valid", out_valid, 0);
        check("t4_drop_end_err", err_overflow, 0);
        push(1, loc(8'h41), loc(8'h42), 1);
        check("t4_next_valid", out_valid, 1);
        check("t4_next_no_loc", out_no_loc, 2);
        check("t4_next_slot0", slot(0), loc(8'h41));
        check("t4_next_slot1", slot(1), loc(8'h42));
        check("t4_next_slot2", slot(2), 0);
        handshake("t4_hs");
`else
        check("t4_err_low", err_overflow, 0);
        check("t4_no_valid", out_valid, 0);
        push(0, loc(8'h3B), '0, 1);
        check("t4_err_low_end", err_overflow, 0);
        check("t4_valid", out_valid, 1);
        check("t4_no_loc", out_no_loc, 9);
        check("t4_slot0", slot(0), loc(8'h31));
        check("t4_slot7", slot(7), loc(8'h38));
        check("t4_slot8", slot(8), loc(8'h39));
        handshake("t4_hs");
`endif

        // Reset in the middle of a TLP
        push(1, loc(8'h51), loc(8'h52), 0);
        push(1, loc(8'h53), loc(8'h54), 0);
        arst = 1'b1;
        step();
        check("t5_rst_valid", out_valid, 0);
        check("t5_rst_in_ready", in_ready, 0);
        check("t5_rst_no_loc", out_no_loc, 0);
        check("t5_rst_slot0", slot(0), 0);
        arst = 1'b0;
        step();
        check("t5_rel_valid", out_valid, 0);
        check("t5_rel_in_ready", in_ready, 1);
        push(0, loc(8'h61), '0, 1);
        check("t5_valid", out_valid, 1);
        check("t5_no_loc", out_no_loc, 1);
        check("t5_slot0", slot(0), loc(8'h61));
        check("t5_slot1", slot(1), 0);
        handshake("t5_hs");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tlp_reassembly_buffer.md
# tlp_reassembly_buffer

Receive-side counterpart of the TX fragmentation buffer. Accepts a TLP as a stream of 128-bit (4 DW) locations, one or two per cycle, and reassembles them into a single wide word of up to 9 locations (header plus payload). It then presents that word to the downstream TLP processing stage with a valid/ready handshake. It sits between the RX data-link-layer interface and the RX TLP decoder.

## Interface
- DW, 32, double-word width in bits
- LOC_W, 4*DW (128), width of one location
- MAX_LOC, 9, maximum locations per TLP; out_data width is MAX_LOC*LOC_W (1152)
- clk  input  1  single clock, all logic on rising edge
- arst  input  1  reset, synchronous, active-high
- in_valid  input  1  input locations valid this cycle
- in_mode  input  1  0: in_data_1 only; 1: in_data_1 then in_data_2
- in_data_1  input  LOC_W  first (older) location
- in_data_2  input  LOC_W  second location, used only when in_mode=1
- in_last  input  1  the last accepted location(s) this cycle end the TLP
- in_ready  output  1  buffer accepts input this cycle
- out_valid  output  1  reassembled TLP available
- out_ready  input  1  downstream consumes TLP
- out_data  output  MAX_LOC*LOC_W  location 0 in bits [MAX_LOC*LOC_W-1 -: LOC_W], location k below it; unused slots zero
- out_no_loc  output  4  number of valid locations, 1..9
- err_overflow  output  1  one-cycle pulse when a TLP exceeds MAX_LOC locations

## Operation
- Accept condition: in_valid && in_ready. Locations written = in_mode+1.
- Internal loc_cnt (4 bits) holds the next write slot. in_data_1 goes to slot loc_cnt; in_data_2 goes to slot loc_cnt+1.
- States:
  - IDLE: loc_cnt=0. An accept moves to COLLECT, or to PRESENT if in_last.
  - COLLECT: keeps accepting. An accept with in_last moves to PRESENT.
  - PRESENT: out_valid=1, in_ready=0. out_valid && out_ready clears slots and loc_cnt and moves to IDLE.
  - DROP: in_ready=1; locations are discarded. An accept with in_last moves to IDLE.
- Overflow: an accept where loc_cnt+in_mode+1 > MAX_LOC (e.g. loc_cnt=8, in_mode=1):
  - err_overflow pulses for one cycle.
  - Stored slots are cleared and loc_cnt is set to 0.
  - The FSM moves to DROP, or to IDLE if in_last is also set. The whole TLP is discarded.
- out_no_loc equals loc_cnt while in PRESENT and is 0 otherwise.
- in_ready = !arst && (state != PRESENT).

## Timing
- Reset (arst high at a clock edge):
  - state=IDLE, loc_cnt=0, all slots 0.
  - out_valid=0, out_data=0, out_no_loc=0, err_overflow=0.
  - in_ready is 0 while arst is high.
- Reset asserted mid-TLP or during PRESENT discards all content on that edge. No output pulse is produced.
- Latency: out_valid rises on the edge that accepts in_last. Minimum input-accept to out_valid is 1 cycle.
- out_data and out_no_loc are registered and stable while out_valid=1 && out_ready=0.
- Handshake at cycle N (out_valid && out_ready): out_valid=0 and in_ready=1 from cycle N+1. There is a minimum one-cycle input bubble per TLP.
- in_valid while in_ready=0 is ignored, not queued.
- A full TLP of exactly MAX_LOC locations is legal and is not an overflow.

## Configuration
- Macro: TLP_REASM_OVF_CHECK_EN.
- Defined: overflow detection, the DROP state and err_overflow behave as specified above.
- Undefined:
  - The DROP state is absent and err_overflow is tied to 0.
  - Writes to slots ≥ MAX_LOC are silently discarded and loc_cnt saturates at MAX_LOC.
  - The TLP is still presented on in_last with out_no_loc=9.

## Test plan
- Reset then 3 single accepts A, B, C (in_mode=0), C with in_last -> out_valid the next cycle, out_no_loc=3, slots 0..2 = A, B, C, remaining 6 slots zero.
- 4 dual accepts plus 1 single accept with in_last (9 locations) -> out_no_loc=9, no err_overflow, in_ready=0 until the out handshake.
- Hold out_ready=0 for 5 cycles with in_valid=1 -> out_data stable, nothing accepted. Raise out_ready -> out_valid=0 and in_ready=1 the next cycle.
- TLP_REASM_OVF_CHECK_EN defined, loc_cnt=8, dual accept without in_last -> err_overflow pulses once, DROP until in_last, no out_valid. The next 2-location TLP is presented correctly.
- Same stimulus with the macro undefined -> err_overflow stays 0, slot 8 holds in_data_1, and out_no_loc=9 on in_last.
- arst asserted after 4 locations collected -> out_valid never rises. After release, a fresh 1-location TLP gives out_no_loc=1.
